wb_initiator: RTL

//  Single-outstanding Wishbone bus initiator driving the same cyc/we/addr/wdata/ack/rdata
//  bus our peripherals (timer, ledstring) respond on. Converts a valid/ready request stream

---
 rtl/wb_initiator_pkg.sv | 21 ++
 rtl/wb_initiator.sv | 115 +++++++++++
 2 files changed

// File: rtl/wb_initiator_pkg.sv
// Shared definitions for the Wishbone initiator: FSM state encoding,
// default bus geometry and the timeout counter width helper.
package wb_initiator_pkg;

    localparam int WB_AW_DEFAULT      = 2;
    localparam int WB_DW_DEFAULT      = 32;
    localparam int WB_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CYC  = 2'd1,
        ST_RSP  = 2'd2
    } wb_state_t;

    // Counter must hold the value TIMEOUT; keep at least one bit so a
    // disabled timeout (0) still gives a legal vector.
    function automatic int cnt_width(input int timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone initiator. Each accepted request becomes one
// bus cycle; the outcome (read data, or a timeout error) is returned on a
// valid/ready response stream. All outputs are registered except req_ready.
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int AW      = WB_AW_DEFAULT,
    parameter int DW      = WB_DW_DEFAULT,
    parameter int TIMEOUT = WB_TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_wdata,
    output logic          wb_we,
    output logic          wb_cyc,
    input  logic [DW-1:0] wb_rdata,
    input  logic          wb_ack
);

    localparam int            CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam bit            TO_EN    = (TIMEOUT != 0);

    wb_state_t     state_reg;
    logic [CW-1:0] cnt_reg;
    logic [AW-1:0] wb_addr_reg;
    logic [DW-1:0] wb_wdata_reg;
    logic          wb_we_reg;
    logic          wb_cyc_reg;
    logic          rsp_valid_reg;
    logic [DW-1:0] rsp_rdata_reg;
    logic          rsp_err_reg;

    // Ready only when idle and out of reset; gating with rst_n keeps it low
    // for the whole reset window even though the state already reads IDLE.
    assign req_ready = rst_n && (state_reg == ST_IDLE);

    assign wb_addr   = wb_addr_reg;
    assign wb_wdata  = wb_wdata_reg;
    assign wb_we     = wb_we_reg;
    assign wb_cyc    = wb_cyc_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

    // Request -> bus cycle -> response sequencer with inline timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            wb_addr_reg   <= '0;
            wb_wdata_reg  <= '0;
            wb_we_reg     <= 1'b0;
            wb_cyc_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        wb_we_reg    <= req_we;
                        wb_addr_reg  <= req_addr;
                        wb_wdata_reg <= req_wdata;
                        wb_cyc_reg   <= 1'b1;
                        cnt_reg      <= CNT_LOAD;
                        state_reg    <= ST_CYC;
                    end
                end
                ST_CYC: begin
                    // An ack on the expiry cycle takes priority over the timeout.
                    if (wb_ack) begin
                        wb_cyc_reg    <= 1'b0;
                        rsp_rdata_reg <= wb_we_reg ? '0 : wb_rdata;
                        rsp_err_reg   <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_RSP;
                    end else if (TO_EN && (cnt_reg == CNT_ONE)) begin
                        wb_cyc_reg    <= 1'b0;
                        rsp_rdata_reg <= '0;
                        rsp_err_reg   <= 1'b1;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_RSP;
                    end else if (cnt_reg != '0) begin
                        // Saturate at zero so a disabled timeout never wraps.
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                ST_RSP: begin
                    // Late acks landing here are ignored; only the consumer moves us on.
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    wb_cyc_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
